// File: rtl/time_entry_ctrl.sv
// Operator front-end for the microwave countdown timer: debounced buttons,
// min/sec setpoint entry with auto-repeat, and start/stop/pause pulse generation.
module time_entry_ctrl #(
    parameter int DEBOUNCE_COUNT = 4,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_PERIOD  = 8,
    parameter int START_TIMEOUT  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       done,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       start,
    output logic       stop,
    output logic       pause,
    output logic       field_sel,
    output logic       editing
);
    localparam int NB = 6;
    localparam int UP = 0, DN = 1, MD = 2, ST = 3, SP = 4, PS = 5;
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {EDIT, ARMED, RUNNING} state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync2_q, lvl_q, lvl_d, prev_q, ready_q, ready_d, press;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic          held_up, held_dn;

    assign raw = {btn_pause, btn_stop, btn_start, btn_mode, btn_down, btn_up};

    // A button only counts once its synchronised level has been seen low, so a key
    // held through reset must be released and pressed again.
    always_comb begin
        lvl_d   = lvl_q;
        ready_d = ready_q | ~sync2_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_COUNT - 1))
                    lvl_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign press   = lvl_q & ~prev_q & ready_q;
    assign held_up = lvl_q[UP] & ready_q[UP];
    assign held_dn = lvl_q[DN] & ready_q[DN];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            lvl_q   <= '0;
            prev_q  <= '0;
            ready_q <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            ready_q <= ready_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    logic [RW-1:0] rep_q, rep_d, rep_inc;
    logic          rep_step;

    // After the first repeat the counter reloads so later steps come every REPEAT_PERIOD.
    always_comb begin
        rep_inc  = rep_q + RW'(1);
        rep_d    = '0;
        rep_step = 1'b0;
        if (!(press[UP] || press[DN]) && (held_up || held_dn)) begin
            if (rep_inc == RW'(REPEAT_DELAY)) begin
                rep_step = 1'b1;
                rep_d    = RW'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rep_d = rep_inc;
            end
        end
    end

    function automatic logic [6:0] step_val(input logic [6:0] v, input logic inc,
                                            input logic [6:0] top);
        if (inc)
            step_val = (v >= top) ? 7'd0 : v + 7'd1;
        else
            step_val = (v == 7'd0) ? top : v - 7'd1;
    endfunction

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d, sec_q, sec_d;
    logic          start_q, start_d, stop_q, stop_d, pause_q, pause_d;
    logic          field_q, field_d, editing_q, editing_d, seen_q, seen_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic          up_ev, dn_ev;

    assign up_ev   = press[UP] | (rep_step & held_up);
    assign dn_ev   = press[DN] | (rep_step & held_dn);
    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        pause_d = 1'b0;
        field_d = field_q;
        tmo_d   = '0;
        seen_d  = 1'b0;
        case (state_q)
            EDIT: begin
                if (press[SP]) begin
                    stop_d = 1'b1;
                    min_d  = 7'd0;
                    sec_d  = 7'd0;
                end else begin
                    if (up_ev ^ dn_ev) begin
                        if (field_q) min_d = step_val(min_q, up_ev, 7'd99);
                        else         sec_d = step_val(sec_q, up_ev, 7'd59);
                    end
                    if (press[ST] && (min_q != 7'd0 || sec_q != 7'd0)) begin
                        start_d = 1'b1;
                        state_d = ARMED;
                    end
                end
                if (press[MD]) field_d = ~field_q;
            end
            ARMED: begin
                if (!done)
                    state_d = RUNNING;
                else if (tmo_inc == TW'(START_TIMEOUT))
                    state_d = EDIT;
                else
                    tmo_d = tmo_inc;
            end
            RUNNING: begin
                stop_d  = press[SP];
                start_d = press[ST] & ~press[SP];
                pause_d = press[PS] & ~press[SP] & ~press[ST];
                seen_d  = done;
                if (done && seen_q) state_d = EDIT;
            end
            default: state_d = EDIT;
        endcase
        editing_d = (state_d == EDIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= EDIT;
            min_q     <= '0;
            sec_q     <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            pause_q   <= 1'b0;
            field_q   <= 1'b0;
            editing_q <= 1'b1;
            seen_q    <= 1'b0;
            tmo_q     <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            pause_q   <= pause_d;
            field_q   <= field_d;
            editing_q <= editing_d;
            seen_q    <= seen_d;
            tmo_q     <= tmo_d;
            rep_q     <= rep_d;
        end
    end

    assign min       = min_q;
    assign sec       = sec_q;
    assign start     = start_q;
    assign stop      = stop_q;
    assign pause     = pause_q;
    assign field_sel = field_q;
    assign editing   = editing_q;
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: setpoint entry, wrap, auto-repeat, run/arm/timeout
// sequencing, event priority and reset behaviour.
module tb_time_entry_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] btns = '0;
    logic       done = 1'b1;
    logic [6:0] min, sec;
    logic       start, stop, pause, field_sel, editing;
    int         checks = 0;
    int         errors = 0;
    int         ns, np, nq;

    localparam logic [5:0] B_UP = 6'b000001, B_DN = 6'b000010, B_MD = 6'b000100;
    localparam logic [5:0] B_ST = 6'b001000, B_SP = 6'b010000, B_PS = 6'b100000;

    always #5 clock = ~clock;

    time_entry_ctrl dut (
        .clock(clock), .reset(reset),
        .btn_up(btns[0]), .btn_down(btns[1]), .btn_mode(btns[2]),
        .btn_start(btns[3]), .btn_stop(btns[4]), .btn_pause(btns[5]),
        .done(done), .min(min), .sec(sec), .start(start), .stop(stop), .pause(pause),
        .field_sel(field_sel), .editing(editing)
    );

    // Press the given buttons for 'hold' cycles, release, and count pulse-high cycles.
    task automatic press(input logic [5:0] mask, input int hold,
                         output int n_start, output int n_stop, output int n_pause);
        n_start = 0; n_stop = 0; n_pause = 0;
        @(negedge clock);
        btns = mask;
        for (int i = 0; i < hold + 12; i++) begin
            @(negedge clock);
            if (i == hold - 1) btns = '0;
            if (start) n_start++;
            if (stop)  n_stop++;
            if (pause) n_pause++;
        end
    endtask

    task automatic tap(input logic [5:0] mask);
        int a, b, c;
        press(mask, 8, a, b, c);
    endtask

    // Hold start and check the pulse lands exactly 7 cycles after the raw edge.
    task automatic timed_start(input string name);
        int early;
        early = 0;
        @(negedge clock);
        btns = B_ST;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k < 7 && start) early++;
        end
        checks++;
        if (early !== 0 || start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_latency: early=%0d start=%b, required early=0 start=1", name, early, start);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({min, sec, start, stop, pause, field_sel, editing} !== {7'd0, 7'd0, 5'b00001}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: min=%0d sec=%0d st=%b sp=%b ps=%b fs=%b ed=%b, required 0 0 0 0 0 0 1",
                     min, sec, start, stop, pause, field_sel, editing);
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_basic_entry;
        repeat (3) tap(B_UP);
        checks++;
        if (sec !== 7'd3 || min !== 7'd0) begin
            errors++; $display("[TB] FAIL up_sec: sec=%0d min=%0d, required 3 0", sec, min);
        end
        tap(B_MD);
        repeat (2) tap(B_UP);
        checks++;
        if (min !== 7'd2 || field_sel !== 1'b1 || sec !== 7'd3) begin
            errors++; $display("[TB] FAIL up_min: min=%0d fs=%b sec=%0d, required 2 1 3", min, field_sel, sec);
        end
    endtask

    task automatic test_wrap;
        press(B_SP, 8, ns, np, nq);
        checks++;
        if (np !== 1 || min !== 7'd0 || sec !== 7'd0) begin
            errors++; $display("[TB] FAIL stop_clear: stops=%0d min=%0d sec=%0d, required 1 0 0", np, min, sec);
        end
        tap(B_DN);
        checks++;
        if (min !== 7'd99) begin
            errors++; $display("[TB] FAIL min_wrap_down: min=%0d, required 99", min);
        end
        tap(B_UP);
        checks++;
        if (min !== 7'd0) begin
            errors++; $display("[TB] FAIL min_wrap_up: min=%0d, required 0", min);
        end
        tap(B_MD);
        tap(B_DN);
        checks++;
        if (sec !== 7'd59 || field_sel !== 1'b0) begin
            errors++; $display("[TB] FAIL sec_wrap_down: sec=%0d fs=%b, required 59 0", sec, field_sel);
        end
        press(B_UP, 3, ns, np, nq);
        checks++;
        if (sec !== 7'd59) begin
            errors++; $display("[TB] FAIL glitch: sec=%0d, required 59", sec);
        end
        tap(B_UP);
        checks++;
        if (sec !== 7'd0) begin
            errors++; $display("[TB] FAIL sec_wrap_up: sec=%0d, required 0", sec);
        end
    endtask

    task automatic test_repeat;
        press(B_UP, 40, ns, np, nq);
        checks++;
        if (sec !== 7'd4) begin
            errors++; $display("[TB] FAIL repeat_steps: sec=%0d, required 4", sec);
        end
        repeat (30) @(negedge clock);
        checks++;
        if (sec !== 7'd4) begin
            errors++; $display("[TB] FAIL repeat_release: sec=%0d, required 4", sec);
        end
    endtask

    task automatic test_run;
        tap(B_MD); tap(B_UP); tap(B_MD); tap(B_UP);
        checks++;
        if (min !== 7'd1 || sec !== 7'd5) begin
            errors++; $display("[TB] FAIL setpoint_1_5: min=%0d sec=%0d, required 1 5", min, sec);
        end
        timed_start("run_start");
        done = 1'b0;
        @(negedge clock);
        checks++;
        if (start !== 1'b0 || editing !== 1'b0) begin
            errors++; $display("[TB] FAIL run_enter: start=%b editing=%b, required 0 0", start, editing);
        end
        btns = '0;
        repeat (12) @(negedge clock);
        tap(B_UP);
        checks++;
        if (sec !== 7'd5 || editing !== 1'b0) begin
            errors++; $display("[TB] FAIL run_locked: sec=%0d editing=%b, required 5 0", sec, editing);
        end
        press(B_PS, 20, ns, np, nq);
        checks++;
        if (nq !== 1 || ns !== 0 || np !== 0) begin
            errors++; $display("[TB] FAIL run_pause: pause=%0d start=%0d stop=%0d, required 1 0 0", nq, ns, np);
        end
        done = 1'b1;
        @(negedge clock);
        checks++;
        if (editing !== 1'b0) begin
            errors++; $display("[TB] FAIL done_one_cycle: editing=%b, required 0", editing);
        end
        @(negedge clock);
        checks++;
        if (editing !== 1'b1 || min !== 7'd1 || sec !== 7'd5) begin
            errors++; $display("[TB] FAIL done_to_edit: editing=%b min=%0d sec=%0d, required 1 1 5", editing, min, sec);
        end
    endtask

    task automatic test_timeout;
        press(B_SP, 8, ns, np, nq);
        press(B_ST, 8, ns, np, nq);
        checks++;
        if (ns !== 0 || editing !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_start: starts=%0d editing=%b, required 0 1", ns, editing);
        end
        tap(B_UP);
        timed_start("arm_start");
        repeat (15) @(negedge clock);
        checks++;
        if (editing !== 1'b0) begin
            errors++; $display("[TB] FAIL armed_wait: editing=%b, required 0", editing);
        end
        @(negedge clock);
        checks++;
        if (editing !== 1'b1) begin
            errors++; $display("[TB] FAIL armed_timeout: editing=%b, required 1", editing);
        end
        btns = '0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_simultaneous;
        press(B_UP | B_DN, 8, ns, np, nq);
        checks++;
        if (sec !== 7'd1) begin
            errors++; $display("[TB] FAIL up_down_same: sec=%0d, required 1", sec);
        end
        press(B_ST | B_SP, 8, ns, np, nq);
        checks++;
        if (ns !== 0 || np !== 1 || min !== 7'd0 || sec !== 7'd0 || editing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_stop_same: starts=%0d stops=%0d min=%0d sec=%0d ed=%b, required 0 1 0 0 1",
                     ns, np, min, sec, editing);
        end
    endtask

    task automatic test_reset_running;
        tap(B_MD); tap(B_UP); tap(B_MD); tap(B_UP);
        timed_start("rst_start");
        done = 1'b0;
        repeat (2) @(negedge clock);
        btns = B_UP;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({min, sec, start, stop, pause, field_sel, editing} !== {7'd0, 7'd0, 5'b00001}) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: min=%0d sec=%0d st=%b sp=%b ps=%b fs=%b ed=%b, required 0 0 0 0 0 0 1",
                     min, sec, start, stop, pause, field_sel, editing);
        end
        done = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checks++;
        if (sec !== 7'd0) begin
            errors++; $display("[TB] FAIL held_through_reset: sec=%0d, required 0", sec);
        end
        btns = '0;
        repeat (12) @(negedge clock);
        tap(B_UP);
        checks++;
        if (sec !== 7'd1) begin
            errors++; $display("[TB] FAIL repress_after_reset: sec=%0d, required 1", sec);
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_wrap();
        test_repeat();
        test_run();
        test_timeout();
        test_simultaneous();
        test_reset_running();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
